// File: rtl/strip_pixel_router.sv
// rtl/strip_pixel_router.sv - steers a raster pixel stream to per-strip RAM writes
// One registered write per accepted pixel, with frame, short-frame and overflow flags.
module strip_pixel_router #(
  parameter int STRIP_COUNT = 8,
  parameter int LED_COUNT   = 300,
  parameter int SERPENTINE  = 0
) (
  input  logic                   pixel_clk_i,
  input  logic                   rst_i,
  input  logic                   pixel_valid_i,
  input  logic                   pixel_sof_i,
  input  logic [7:0]             pixel_r_i,
  input  logic [7:0]             pixel_g_i,
  input  logic [7:0]             pixel_b_i,
  output logic [7:0]             pixel_r_o,
  output logic [7:0]             pixel_g_o,
  output logic [7:0]             pixel_b_o,
  output logic [8:0]             led_address_o,
  output logic [STRIP_COUNT-1:0] led_address_valid_o,
  output logic                   frame_done_o,
  output logic                   short_frame_o,
  output logic                   overflow_o
);

  localparam logic [8:0] LED_LAST   = 9'(LED_COUNT - 1);
  localparam logic [3:0] STRIP_LAST = 4'(STRIP_COUNT - 1);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                 state, state_nx;
  logic [8:0]             led_idx, led_nx;
  logic [3:0]             strip_idx, strip_nx;
  logic                   wr;
  logic [8:0]             wr_led;
  logic [3:0]             wr_strip;
  logic [8:0]             wr_addr;
  logic [STRIP_COUNT-1:0] strobe_nx;
  logic                   done_nx, short_nx, ovf_nx;

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= WAIT_SOF;
      led_idx   <= '0;
      strip_idx <= '0;
    end else begin
      state     <= state_nx;
      led_idx   <= led_nx;
      strip_idx <= strip_nx;
    end
  end

  always_comb begin
    state_nx = state;
    led_nx   = led_idx;
    strip_nx = strip_idx;
    wr       = 1'b0;
    wr_led   = led_idx;
    wr_strip = strip_idx;
    done_nx  = 1'b0;
    short_nx = 1'b0;
    ovf_nx   = overflow_o;

    if (pixel_valid_i) begin
      if (pixel_sof_i) begin
        // SOF always restarts at (0,0); inside a frame it also reports the truncation
        wr       = 1'b1;
        wr_led   = '0;
        wr_strip = '0;
        ovf_nx   = 1'b0;
        short_nx = (state == ACTIVE);
      end else if (state == ACTIVE) begin
        wr = 1'b1;
      end else begin
        ovf_nx = 1'b1;
      end
    end

    if (wr) begin
      if (wr_strip == STRIP_LAST && wr_led == LED_LAST) begin
        done_nx  = 1'b1;
        led_nx   = '0;
        strip_nx = '0;
        state_nx = WAIT_SOF;
      end else begin
        state_nx = ACTIVE;
        if (wr_led == LED_LAST) begin
          led_nx   = '0;
          strip_nx = wr_strip + 4'd1;
        end else begin
          led_nx   = wr_led + 9'd1;
          strip_nx = wr_strip;
        end
      end
    end

    wr_addr   = (SERPENTINE != 0 && wr_strip[0]) ? (LED_LAST - wr_led) : wr_led;
    strobe_nx = wr ? (STRIP_COUNT'(1) << wr_strip) : '0;
  end

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      pixel_r_o           <= '0;
      pixel_g_o           <= '0;
      pixel_b_o           <= '0;
      led_address_o       <= '0;
      led_address_valid_o <= '0;
      frame_done_o        <= 1'b0;
      short_frame_o       <= 1'b0;
      overflow_o          <= 1'b0;
    end else begin
      led_address_valid_o <= strobe_nx;
      frame_done_o        <= done_nx;
      short_frame_o       <= short_nx;
      overflow_o          <= ovf_nx;
      if (wr) begin
        pixel_r_o     <= pixel_r_i;
        pixel_g_o     <= pixel_g_i;
        pixel_b_o     <= pixel_b_i;
        led_address_o <= wr_addr;
      end
    end
  end

endmodule
